// File: rtl/cpu_irq_pkg.sv
// Shared types and constants for the CPU interrupt controller.
// Holds the dispatch FSM encoding, register selects and vector defaults.
package cpu_irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACKD = 2'd2
    } irq_state_e;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_IE = 1'b1;

    localparam logic [7:0] DEF_VEC_BASE   = 8'h40;
    localparam logic [7:0] DEF_VEC_STRIDE = 8'd8;

endpackage

// File: rtl/cpu_irq_ctrl_if.sv
// CPU-side bus of the interrupt controller: register access plus
// the instruction/dispatch handshake with the Sequencer.
interface cpu_irq_ctrl_if;

    logic       REG_SEL;
    logic       REG_WR;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       INSTR_END;
    logic       EI_EXEC;
    logic       DI_EXEC;
    logic       RETI_EXEC;
    logic       INT_ACK;
    logic       INT_REQ;
    logic [7:0] VECTOR;
    logic       VEC_VALID;
    logic       WAKE;

    modport master (
        output REG_SEL, REG_WR, DIN,
        output INSTR_END, EI_EXEC, DI_EXEC, RETI_EXEC, INT_ACK,
        input  DOUT, INT_REQ, VECTOR, VEC_VALID, WAKE
    );

    modport slave (
        input  REG_SEL, REG_WR, DIN,
        input  INSTR_END, EI_EXEC, DI_EXEC, RETI_EXEC, INT_ACK,
        output DOUT, INT_REQ, VECTOR, VEC_VALID, WAKE
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 has the highest priority.
// Produces the winning index and a flag that any request is present.
module irq_prio_enc #(
    parameter int N  = 5,
    parameter int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    output logic [SW-1:0] o_sel,
    output logic          o_any
);

    always_comb begin
        o_sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) o_sel = SW'(i);
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/cpu_irq_ctrl.sv
// Interrupt controller: IF/IE/IME state, request edge detection,
// wake/dispatch requests and the vector handshake with the Sequencer.
module cpu_irq_ctrl
    import cpu_irq_pkg::*;
#(
    parameter int               N_SRC      = 5,
    parameter logic [7:0]       VEC_BASE   = DEF_VEC_BASE,
    parameter logic [7:0]       VEC_STRIDE = DEF_VEC_STRIDE,
    parameter logic [N_SRC-1:0] IF_INIT    = '0
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic [N_SRC-1:0] IRQ_IN,
    cpu_irq_ctrl_if.slave    bus,
    output logic             IME
);

    localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    irq_state_e       r_state;
    logic [N_SRC-1:0] r_if;
    logic [7:0]       r_ie;
    logic             r_ime;
    logic             r_eip;
    logic [N_SRC-1:0] r_prev;
    logic             r_int_req;
    logic             r_vec_valid;
    logic [7:0]       r_vector;
    logic             r_wake;

    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_pend;
    logic [SW-1:0]    w_sel;
    logic             w_any;
    logic             w_ack;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_if_base;
    logic [N_SRC-1:0] w_if_nxt;
    logic             w_ime_nxt;
    logic             w_eip_nxt;
    logic [7:0]       w_vec;

    assign w_rise = IRQ_IN & ~r_prev;
    assign w_pend = r_if & r_ie[N_SRC-1:0];
    assign w_ack  = (r_state == ST_REQ) && bus.INT_ACK;

    irq_prio_enc #(.N(N_SRC), .SW(SW)) u_prio (
        .i_req (w_pend),
        .o_sel (w_sel),
        .o_any (w_any)
    );

    assign w_clr = (w_ack && w_any) ? (N_SRC'(1) << w_sel) : '0;
    assign w_vec = w_any ? (VEC_BASE + VEC_STRIDE * 8'(w_sel)) : 8'h00;

    // Edge set beats the ACK clear, which beats a register write.
    always_comb begin
        w_if_base = r_if;
        if (bus.REG_WR && bus.REG_SEL == SEL_IF) begin
            w_if_base = bus.DIN[N_SRC-1:0];
        end
        w_if_nxt = (w_if_base & ~w_clr) | w_rise;
    end

    // DI last so that EI followed directly by DI leaves IME off.
    always_comb begin
        w_ime_nxt = r_ime;
        w_eip_nxt = r_eip;
        if (r_eip && bus.INSTR_END) begin
            w_ime_nxt = 1'b1;
            w_eip_nxt = 1'b0;
        end
        if (bus.RETI_EXEC) w_ime_nxt = 1'b1;
        if (bus.EI_EXEC)   w_eip_nxt = 1'b1;
        if (bus.DI_EXEC) begin
            w_ime_nxt = 1'b0;
            w_eip_nxt = 1'b0;
        end
        if (w_ack) w_ime_nxt = 1'b0;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_if   <= IF_INIT;
            r_ie   <= 8'h00;
            r_ime  <= 1'b0;
            r_eip  <= 1'b0;
            r_prev <= '0;
            r_wake <= 1'b0;
        end else begin
            r_if   <= w_if_nxt;
            r_ime  <= w_ime_nxt;
            r_eip  <= w_eip_nxt;
            r_prev <= IRQ_IN;
            r_wake <= |w_pend;
            if (bus.REG_WR && bus.REG_SEL == SEL_IE) r_ie <= bus.DIN;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state     <= ST_IDLE;
            r_int_req   <= 1'b0;
            r_vec_valid <= 1'b0;
            r_vector    <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.INSTR_END && w_ime_nxt && |w_pend) begin
                        r_state   <= ST_REQ;
                        r_int_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus.INT_ACK) begin
                        r_state     <= ST_ACKD;
                        r_int_req   <= 1'b0;
                        r_vec_valid <= 1'b1;
                        r_vector    <= w_vec;
                    end
                end
                ST_ACKD: begin
                    r_state     <= ST_IDLE;
                    r_vec_valid <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_int_req   <= 1'b0;
                    r_vec_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DOUT = (bus.REG_SEL == SEL_IE) ? r_ie
                                              : {{(8-N_SRC){1'b1}}, r_if};
    assign bus.INT_REQ   = r_int_req;
    assign bus.VEC_VALID = r_vec_valid;
    assign bus.VECTOR    = r_vector;
    assign bus.WAKE      = r_wake;
    assign IME           = r_ime;

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// Directed and randomized checks of cpu_irq_ctrl against a
// cycle-level behavioural model of the interrupt rules.
module tb_cpu_irq_ctrl;

    logic       CLK    = 1'b0;
    logic       nRESET = 1'b0;
    logic [4:0] IRQ_IN = 5'h00;
    logic       IME;

    cpu_irq_ctrl_if bus();

    cpu_irq_ctrl dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .IRQ_IN (IRQ_IN),
        .bus    (bus),
        .IME    (IME)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Model: phase 0 = idle, 1 = request raised, 2 = vector handed over
    logic [4:0] m_if, m_prev;
    logic [7:0] m_ie, m_vec;
    logic       m_ime, m_eip, m_req, m_vv, m_wake;
    int         m_phase;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_if = 5'h00; m_prev = 5'h00; m_ie = 8'h00; m_vec = 8'h00;
        m_ime = 0; m_eip = 0; m_req = 0; m_vv = 0; m_wake = 0;
        m_phase = 0;
    endtask

    task automatic tick();
        logic [4:0] pend, rise, nif;
        logic [7:0] nie;
        logic       ime_n, eip_n;
        int         lo;
        pend = m_if & m_ie[4:0];
        rise = IRQ_IN & ~m_prev;
        lo = -1;
        for (int i = 4; i >= 0; i--) if (pend[i]) lo = i;
        ime_n = m_ime;
        eip_n = m_eip;
        if (m_eip && bus.INSTR_END) begin ime_n = 1; eip_n = 0; end
        if (bus.RETI_EXEC) ime_n = 1;
        if (bus.EI_EXEC) eip_n = 1;
        if (bus.DI_EXEC) begin ime_n = 0; eip_n = 0; end
        nif = (bus.REG_WR && !bus.REG_SEL) ? bus.DIN[4:0] : m_if;
        nie = (bus.REG_WR && bus.REG_SEL) ? bus.DIN : m_ie;
        case (m_phase)
            0: if (bus.INSTR_END && ime_n && pend != 0) begin
                m_phase = 1; m_req = 1;
            end
            1: if (bus.INT_ACK) begin
                m_phase = 2; m_req = 0; m_vv = 1; ime_n = 0;
                m_vec = (lo >= 0) ? 8'(8'h40 + 8 * lo) : 8'h00;
                if (lo >= 0) nif[lo] = 1'b0;
            end
            default: begin m_phase = 0; m_vv = 0; end
        endcase
        nif = nif | rise;
        @(posedge CLK);
        #1;
        m_if = nif; m_ie = nie; m_ime = ime_n; m_eip = eip_n;
        m_prev = IRQ_IN; m_wake = (pend != 0);
        bus.REG_WR = 0; bus.INSTR_END = 0; bus.EI_EXEC = 0;
        bus.DI_EXEC = 0; bus.RETI_EXEC = 0; bus.INT_ACK = 0;
        chk("int_req", bus.INT_REQ, m_req);
        chk("vec_valid", bus.VEC_VALID, m_vv);
        chk("vector", bus.VECTOR, m_vec);
        chk("wake", bus.WAKE, m_wake);
        chk("ime", IME, m_ime);
        chk("dout", bus.DOUT, bus.REG_SEL ? m_ie : {3'b111, m_if});
    endtask

    task automatic peek();
        bus.REG_SEL = 0; #1;
        chk("peek_if", bus.DOUT, {3'b111, m_if});
        bus.REG_SEL = 1; #1;
        chk("peek_ie", bus.DOUT, m_ie);
        bus.REG_SEL = 0;
    endtask

    task automatic wr(input logic sel, input logic [7:0] d);
        bus.REG_SEL = sel; bus.DIN = d; bus.REG_WR = 1;
        tick();
    endtask

    task automatic instr(input logic ei, input logic di, input logic reti);
        bus.INSTR_END = 1; bus.EI_EXEC = ei;
        bus.DI_EXEC = di; bus.RETI_EXEC = reti;
        tick();
    endtask

    task automatic ack();
        bus.INT_ACK = 1;
        tick();
    endtask

    initial begin
        bus.REG_SEL = 0; bus.REG_WR = 0; bus.DIN = 8'h00;
        bus.INSTR_END = 0; bus.EI_EXEC = 0; bus.DI_EXEC = 0;
        bus.RETI_EXEC = 0; bus.INT_ACK = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_int_req", bus.INT_REQ, 8'h00);
        chk("rst_vec_valid", bus.VEC_VALID, 8'h00);
        chk("rst_vector", bus.VECTOR, 8'h00);
        chk("rst_wake", bus.WAKE, 8'h00);
        chk("rst_ime", IME, 8'h00);
        peek();
        @(negedge CLK) nRESET = 1;

        // Basic dispatch from source 2
        wr(1, 8'h04);
        instr(0, 0, 1);
        IRQ_IN = 5'b00100;
        tick();
        tick();
        chk("basic_wake", bus.WAKE, 8'h01);
        instr(0, 0, 0);
        chk("basic_req", bus.INT_REQ, 8'h01);
        ack();
        chk("basic_vv", bus.VEC_VALID, 8'h01);
        chk("basic_vec", bus.VECTOR, 8'h50);
        chk("basic_ime", IME, 8'h00);
        peek();
        tick();
        IRQ_IN = 5'b00000;
        tick();

        // Priority among several pending sources
        wr(0, 8'h1C);
        wr(1, 8'h1F);
        instr(0, 0, 1);
        chk("prio_req", bus.INT_REQ, 8'h01);
        ack();
        chk("prio_vec1", bus.VECTOR, 8'h50);
        peek();
        chk("prio_if1", {3'b000, m_if}, 8'h18);
        tick();
        instr(0, 0, 1);
        ack();
        chk("prio_vec2", bus.VECTOR, 8'h58);
        tick();
        wr(0, 8'h00);
        wr(1, 8'h00);

        // EI takes effect one instruction late
        wr(0, 8'h01);
        wr(1, 8'h01);
        instr(1, 0, 0);
        chk("ei_noreq", bus.INT_REQ, 8'h00);
        instr(0, 0, 0);
        chk("ei_req", bus.INT_REQ, 8'h01);
        ack();
        chk("ei_vec", bus.VECTOR, 8'h40);
        tick();

        // EI immediately followed by DI
        wr(0, 8'h01);
        instr(1, 0, 0);
        instr(0, 1, 0);
        chk("di_noreq", bus.INT_REQ, 8'h00);
        instr(0, 0, 0);
        chk("di_noreq2", bus.INT_REQ, 8'h00);
        chk("di_ime", IME, 8'h00);

        // Dispatch cancelled by clearing IE
        instr(0, 0, 1);
        wr(1, 8'h00);
        chk("cancel_hold", bus.INT_REQ, 8'h01);
        ack();
        chk("cancel_vec", bus.VECTOR, 8'h00);
        chk("cancel_vv", bus.VEC_VALID, 8'h01);
        chk("cancel_ime", IME, 8'h00);
        peek();
        tick();

        // Edge set collides with write and with ACK clear
        IRQ_IN = 5'b00010;
        wr(0, 8'h00);
        bus.REG_SEL = 0; #1;
        chk("coll_wr", bus.DOUT, 8'hE2);
        IRQ_IN = 5'b00000;
        tick();
        wr(0, 8'h08);
        wr(1, 8'h08);
        instr(0, 0, 1);
        IRQ_IN = 5'b01000;
        ack();
        chk("coll_vec", bus.VECTOR, 8'h58);
        bus.REG_SEL = 0; #1;
        chk("coll_ack", bus.DOUT, 8'hE8);
        IRQ_IN = 5'b00000;
        tick();
        tick();

        // Asynchronous reset in the middle of a request
        instr(0, 0, 1);
        chk("mid_req", bus.INT_REQ, 8'h01);
        #2 nRESET = 0;
        #1;
        chk("arst_int_req", bus.INT_REQ, 8'h00);
        chk("arst_ime", IME, 8'h00);
        model_reset();
        peek();
        @(negedge CLK) nRESET = 1;
        tick();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) IRQ_IN = 5'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                bus.REG_SEL = 1'($urandom);
                bus.DIN = 8'($urandom);
                bus.REG_WR = 1;
            end
            if ($urandom_range(0, 2) == 0) begin
                bus.INSTR_END = 1;
                case ($urandom_range(0, 5))
                    0: bus.EI_EXEC = 1;
                    1: bus.DI_EXEC = 1;
                    2: bus.RETI_EXEC = 1;
                    default: ;
                endcase
            end
            bus.INT_ACK = ($urandom_range(0, 3) == 0);
            tick();
            if (k % 16 == 0) peek();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_irq_ctrl.md
Name: cpu_irq_ctrl

Overview:
- Interrupt controller directly upstream of the Sequencer.
- Holds IF/IE/IME and edge-detects peripheral requests.
- Drives WAKE, which brings the Sequencer out of HALT/STOP, and INT_REQ, which makes the Sequencer start the dispatch microcode.
- Completes the dispatch handshake by supplying the vector byte and clearing the serviced flag.

Parameters:
N_SRC, 5, number of interrupt sources (bit 0 = highest priority)
VEC_BASE, 8'h40, vector for source 0
VEC_STRIDE, 8, vector spacing in bytes
IF_INIT, 5'h00, IF value after reset

Ports:
CLK  in  1  single system clock, all state updates on posedge
nRESET  in  1  asynchronous active-low reset
IRQ_IN  in  N_SRC  raw peripheral request levels, synchronous to CLK
REG_SEL  in  1  register select: 0 = IF (FF0F), 1 = IE (FFFF)
REG_WR  in  1  write strobe, one cycle
DIN  in  8  write data
DOUT  out  8  read data for the selected register (combinational mux of registered state)
INSTR_END  in  1  one-cycle pulse on the last cycle of each instruction
EI_EXEC  in  1  EI executed (coincides with its INSTR_END)
DI_EXEC  in  1  DI executed
RETI_EXEC  in  1  RETI executed
INT_ACK  in  1  Sequencer dispatch microcode requests the vector, one cycle
INT_REQ  out  1  dispatch request to the Sequencer
VECTOR  out  8  vector byte
VEC_VALID  out  1  VECTOR valid, one cycle
WAKE  out  1  wake request to the Sequencer
IME  out  1  master enable (debug/visibility)

Behaviour:
- Reset values: IF = IF_INIT, IE = 8'h00, IME = 0, ei_pend = 0, irq_prev = 0, FSM = IDLE. Outputs INT_REQ = 0, VEC_VALID = 0, VECTOR = 8'h00, WAKE = 0.
- Reset is asynchronous; assertion mid-dispatch aborts to IDLE immediately.
- Edge detect: rise = IRQ_IN & ~irq_prev, with irq_prev registered each cycle. A set bit in rise sets the matching IF bit on the same clock edge.
- IF write: IF <= DIN[N_SRC-1:0].
- IF read: DOUT = {3'b111, IF}.
- IE: 8 bits, read and written in full. Only IE[N_SRC-1:0] takes part in the pending calculation.
- IF priority in one cycle: reset > edge set > ACK clear > register write. Per bit, a set always wins.
- pend = IF & IE[N_SRC-1:0].
- WAKE = registered |pend, one cycle latency, independent of IME.
- IME rules:
  - DI_EXEC: clears IME and ei_pend.
  - EI_EXEC: sets ei_pend.
  - ei_pend && INSTR_END on a later instruction: IME <= 1, ei_pend <= 0. This gives one instruction of delay.
  - RETI_EXEC: IME <= 1 immediately.
  - EI then DI back-to-back: IME stays 0.
  - Reaching state ACKD: IME <= 0.
- FSM states:
  - IDLE: on INSTR_END && IME && |pend, go to REQ and assert INT_REQ, registered.
  - REQ: INT_REQ = 1 while waiting. On INT_ACK, re-evaluate pend in that cycle:
    - sel = lowest set bit of pend.
    - VECTOR <= VEC_BASE + VEC_STRIDE*sel.
    - Clear IF[sel], IME <= 0, go to ACKD.
    - If pend == 0 at INT_ACK (IE/IF rewritten during dispatch), VECTOR <= 8'h00, no IF bit is cleared, IME still clears.
  - ACKD: VEC_VALID = 1 and INT_REQ = 0 for exactly one cycle, then IDLE. VECTOR holds its value until the next ACKD.
- INT_ACK in IDLE or ACKD: ignored.
- INT_REQ stays high in REQ even if pend falls; only INT_ACK or reset leaves REQ.
- The vector adder is 8-bit wrap-around.

Decomposition:
- Shared package `cpu_irq_pkg`:
  - FSM state enum (IDLE/REQ/ACKD).
  - Register select constants (SEL_IF = 0, SEL_IE = 1).
  - Default VEC_BASE and VEC_STRIDE.
- One sub-module `irq_prio_enc`: combinational lowest-set-bit encoder producing sel index and any flag. Everything else stays flat.

Test Plan:
- Reset check: pulse nRESET low mid-REQ -> INT_REQ = 0, IF = IF_INIT, DOUT(IF) = 8'hE0, IE = 8'h00, IME = 0 asynchronously.
- Basic dispatch:
  - Stimulus: IE = 8'h04, RETI_EXEC, rising IRQ_IN[2], INSTR_END.
  - Response: WAKE after 1 cycle, INT_REQ next cycle. INT_ACK -> one cycle later VEC_VALID = 1, VECTOR = 8'h50, IF[2] = 0, IME = 0.
- Priority:
  - Stimulus: IF = 5'h1C, IE = 8'h1F, IME = 1, INSTR_END.
  - Response: first ACK gives 8'h50 with IF = 5'h18. Second dispatch (after RETI) gives 8'h58.
- EI delay:
  - Stimulus: IF = 1, IE = 1, EI_EXEC + INSTR_END, then INSTR_END.
  - Response: no INT_REQ after the first INSTR_END; INT_REQ after the second.
  - Also: DI on the next instruction -> INT_REQ never asserts.
- Cancelled dispatch: in REQ, write IE = 0, then INT_ACK -> VECTOR = 8'h00, VEC_VALID pulses, IF unchanged, IME = 0.
- Collision: IF write 5'h00 in the same cycle as IRQ_IN[1] rising -> IF = 5'h02. ACK clearing bit 3 while IRQ_IN[3] rises -> IF[3] = 1.
